sim_sequencer: RTL

SIM_SEQUENCER -- requirements
Module: sim_sequencer

---
 rtl/sim_sequencer_if.sv | 46 ++++
 rtl/sim_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sim_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sim_sequencer_if
// Description : Datapath control/status and result handshake bundle between
//               the simulation sequencer (master) and its datapath/consumer
//               (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sim_sequencer_if #(
   parameter int RULES     = 64,
   parameter int LOG_RULES = 6,
   parameter int LOG_ITER  = 16
);
   // datapath control
   logic                 dp_rst;
   logic                 dp_start;
   logic                 dp_ld_inhibitor;
   logic [LOG_RULES-1:0] dp_sel_inhibitor;
   logic [63:0]          dp_seed;
   // datapath status
   logic [RULES-1:0]     dp_network_state;
   logic                 dp_steady_state;
   logic [LOG_ITER-1:0]  dp_iteration_number;
   // result stream
   logic                 res_valid;
   logic                 res_ready;
   logic [15:0]          res_run_idx;
   logic [RULES-1:0]     res_state;
   logic [LOG_ITER-1:0]  res_iter;
   logic                 res_timeout;

   modport master (
      output dp_rst, dp_start, dp_ld_inhibitor, dp_sel_inhibitor, dp_seed,
      input  dp_network_state, dp_steady_state, dp_iteration_number,
      output res_valid, res_run_idx, res_state, res_iter, res_timeout,
      input  res_ready
   );

   modport slave (
      input  dp_rst, dp_start, dp_ld_inhibitor, dp_sel_inhibitor, dp_seed,
      output dp_network_state, dp_steady_state, dp_iteration_number,
      input  res_valid, res_run_idx, res_state, res_iter, res_timeout,
      output res_ready
   );
endinterface
`default_nettype wire

// File: rtl/sim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sim_sequencer
// Description : Runs a campaign of datapath simulations. Each run resets the
//               datapath, loads the inhibitor list, starts it with a per-run
//               seed, waits for steady state (or a timeout) and emits one
//               result over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sim_sequencer #(
   parameter int RULES          = 64,
   parameter int LOG_RULES      = 6,
   parameter int LOG_ITER       = 16,
   parameter int MAX_INHIB      = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          go,
   input  logic [15:0]                   num_runs,
   input  logic [63:0]                   base_seed,
   input  logic [$clog2(MAX_INHIB):0]    inhib_count,
   input  logic                          inhib_wr_en,
   input  logic [$clog2(MAX_INHIB)-1:0]  inhib_wr_idx,
   input  logic [LOG_RULES-1:0]          inhib_wr_rule,
   sim_sequencer_if.master               bus,
   output logic                          busy,
   output logic                          done
);

   localparam int LOG_MAX = $clog2(MAX_INHIB);
   localparam int CNT_W   = LOG_MAX + 1;
   localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DPRST = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_EMIT  = 3'd5;
   localparam logic [2:0] S_NEXT  = 3'd6;
   localparam logic [2:0] S_FIN   = 3'd7;

   logic [2:0]           state;
   logic [2:0]           state_nxt;

   logic [15:0]          run_idx;
   logic [15:0]          num_runs_q;
   logic [63:0]          base_seed_q;
   logic [CNT_W-1:0]     inhib_cnt_q;
   logic [CNT_W-1:0]     load_idx;
   logic [TMO_W-1:0]     wait_cnt;
   logic [63:0]          seed_q;
   logic [RULES-1:0]     cap_state;
   logic [LOG_ITER-1:0]  cap_iter;
   logic                 cap_timeout;
   logic [LOG_RULES-1:0] inhib_list [MAX_INHIB];

   logic [CNT_W-1:0]     count_clamped;
   logic [15:0]          next_run;
   logic                 last_run;
   logic                 load_last;
   logic                 timeout_hit;
   logic                 wait_exit;
   logic [63:0]          next_seed_sum;

   // output-decode intermediates
   logic                 dp_rst_o;
   logic                 dp_start_o;
   logic                 dp_ld_o;
   logic [LOG_RULES-1:0] dp_sel_o;
   logic                 res_valid_o;

   // A zero seed would stall the datapath's generator, so it is replaced by 1.
   function automatic logic [63:0] seed_fix(input logic [63:0] s);
      return (s == 64'd0) ? 64'd1 : s;
   endfunction

   assign count_clamped = (inhib_count > CNT_W'(MAX_INHIB)) ? CNT_W'(MAX_INHIB) : inhib_count;
   assign next_run      = run_idx + 16'd1;
   assign last_run      = (next_run == num_runs_q);
   assign load_last     = (load_idx == (inhib_cnt_q - CNT_W'(1)));
   assign timeout_hit   = (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   assign wait_exit     = bus.dp_steady_state | timeout_hit;
   assign next_seed_sum = base_seed_q + {48'd0, next_run};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (go) state_nxt = (num_runs == 16'd0) ? S_FIN : S_DPRST;
         S_DPRST: state_nxt = (inhib_cnt_q == '0) ? S_START : S_LOAD;
         S_LOAD:  if (load_last) state_nxt = S_START;
         S_START: state_nxt = S_WAIT;
         S_WAIT:  if (wait_exit) state_nxt = S_EMIT;
         S_EMIT:  if (bus.res_ready) state_nxt = S_NEXT;
         S_NEXT:  state_nxt = last_run ? S_FIN : S_DPRST;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Moore output decode; res_valid depends on state only.
   always_comb begin
      dp_rst_o    = 1'b0;
      dp_start_o  = 1'b0;
      dp_ld_o     = 1'b0;
      dp_sel_o    = '0;
      res_valid_o = 1'b0;
      busy        = (state != S_IDLE);
      done        = (state == S_FIN);
      case (state)
         S_DPRST: dp_rst_o = 1'b1;
         S_LOAD: begin
            dp_ld_o  = 1'b1;
            dp_sel_o = inhib_list[load_idx[LOG_MAX-1:0]];
         end
         S_START: dp_start_o = 1'b1;
         S_EMIT:  res_valid_o = 1'b1;
         default: ;
      endcase
   end

   // Campaign parameters, run counters, seed and captured result.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_idx     <= '0;
         num_runs_q  <= '0;
         base_seed_q <= '0;
         inhib_cnt_q <= '0;
         load_idx    <= '0;
         wait_cnt    <= '0;
         seed_q      <= '0;
         cap_state   <= '0;
         cap_iter    <= '0;
         cap_timeout <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (go) begin
                  num_runs_q  <= num_runs;
                  base_seed_q <= base_seed;
                  inhib_cnt_q <= count_clamped;
                  run_idx     <= '0;
                  if (num_runs != 16'd0) begin
                     seed_q <= seed_fix(base_seed);
                  end
               end
            end
            S_DPRST: load_idx <= '0;
            S_LOAD:  load_idx <= load_idx + CNT_W'(1);
            S_START: wait_cnt <= '0;
            S_WAIT: begin
               wait_cnt <= wait_cnt + TMO_W'(1);
               if (wait_exit) begin
                  cap_state   <= bus.dp_network_state;
                  cap_iter    <= bus.dp_iteration_number;
                  // steady wins a tie with the timeout
                  cap_timeout <= ~bus.dp_steady_state;
               end
            end
            S_NEXT: begin
               run_idx <= next_run;
               if (!last_run) begin
                  seed_q <= seed_fix(next_seed_sum);
               end
            end
            default: ;
         endcase
      end
   end

   // Inhibitor list storage; writable only while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAX_INHIB; i++) begin
            inhib_list[i] <= '0;
         end
      end else if (inhib_wr_en && (state == S_IDLE)) begin
         inhib_list[inhib_wr_idx] <= inhib_wr_rule;
      end
   end

   assign bus.dp_rst           = dp_rst_o;
   assign bus.dp_start         = dp_start_o;
   assign bus.dp_ld_inhibitor  = dp_ld_o;
   assign bus.dp_sel_inhibitor = dp_sel_o;
   assign bus.dp_seed          = seed_q;
   assign bus.res_valid        = res_valid_o;
   assign bus.res_run_idx      = run_idx;
   assign bus.res_state        = cap_state;
   assign bus.res_iter         = cap_iter;
   assign bus.res_timeout      = cap_timeout;

endmodule
`default_nettype wire
